// File: rtl/key_press_gen_if.sv
// Key pin and press-pulse bundle between the board buttons and game-control logic.
// Press outputs are one-cycle strobes with no back-pressure; key_level is a steady debounced level.
interface key_press_gen_if;
   logic [3:0] key_n;
   logic       key1_press;
   logic       key2_press;
   logic       key3_press;
   logic       key4_press;
   logic       any_press;
   logic [3:0] key_level;
   logic [7:0] key_state;   // 2-bit FSM state per key, key i at [2*i +: 2]

   modport master (
      output key_n,
      input  key1_press, key2_press, key3_press, key4_press,
      input  any_press, key_level, key_state
   );

   modport slave (
      input  key_n,
      output key1_press, key2_press, key3_press, key4_press,
      output any_press, key_level, key_state
   );
endinterface

// File: rtl/key_press_gen.sv
// Synchronises and debounces four active-low buttons into one-cycle press pulses,
// debounced levels and optional auto-repeat pulses while a key stays held.
module key_press_gen #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter bit REPEAT_EN       = 1'b0,
   parameter int REPEAT_DELAY    = 25_000_000,
   parameter int REPEAT_PERIOD   = 5_000_000
) (
   input logic           clk,
   input logic           rst,
   key_press_gen_if.slave bus
);

   localparam int MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
   localparam int MAX_P = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
   localparam int CW    = $clog2(MAX_P) + 1;

   localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } key_state_e;

   logic [3:0] sync1;
   logic [3:0] key_sync;
   logic [3:0] press;
   logic [3:0] level;

   // Reset to all-ones so the FSMs see released keys until real samples arrive
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1    <= '1;
         key_sync <= '1;
      end else begin
         sync1    <= bus.key_n;
         key_sync <= sync1;
      end
   end

   for (genvar i = 0; i < 4; i++) begin : g_key
      key_state_e    state_q, state_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic [CW-1:0] rpt_q, rpt_d;
      logic          armed_q, armed_d;
      logic          press_q, press_d;
      logic          level_q, level_d;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rpt_q   <= '0;
            armed_q <= 1'b0;
            press_q <= 1'b0;
            level_q <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rpt_q   <= rpt_d;
            armed_q <= armed_d;
            press_q <= press_d;
            level_q <= level_d;
         end
      end

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         rpt_d   = rpt_q;
         armed_d = armed_q;
         press_d = 1'b0;
         level_d = level_q;
         unique case (state_q)
            IDLE: begin
               if (!key_sync[i]) begin
                  state_d = PRESS_WAIT;
                  cnt_d   = '0;
               end
            end
            PRESS_WAIT: begin
               if (key_sync[i]) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else if (cnt_q == DB_LAST) begin
                  state_d = HELD;
                  cnt_d   = '0;
                  press_d = 1'b1;
                  level_d = 1'b1;
                  rpt_d   = '0;
                  armed_d = 1'b0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            HELD: begin
               if (key_sync[i]) begin
                  state_d = RELEASE_WAIT;
                  cnt_d   = '0;
               end else if (REPEAT_EN) begin
                  // With a threshold of one the repeat waits a cycle so pulses never merge
                  if (rpt_q == (armed_q ? PER_LAST : DLY_LAST)) begin
                     if (!press_q) begin
                        press_d = 1'b1;
                        rpt_d   = '0;
                        armed_d = 1'b1;
                     end
                  end else begin
                     rpt_d = rpt_q + 1'b1;
                  end
               end
            end
            RELEASE_WAIT: begin
               if (!key_sync[i]) begin
                  state_d = HELD;
                  cnt_d   = '0;
               end else if (cnt_q == DB_LAST) begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  level_d = 1'b0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      assign press[i]               = press_q;
      assign level[i]               = level_q;
      assign bus.key_state[2*i +: 2] = state_q;
   end

   assign bus.key1_press = press[0];
   assign bus.key2_press = press[1];
   assign bus.key3_press = press[2];
   assign bus.key4_press = press[3];
   assign bus.any_press  = |press;
   assign bus.key_level  = level;

endmodule

// File: tb/tb_key_press_gen.sv
// Directed bench for key_press_gen: press pulses are scheduled into expected queues
// as keys are driven and compared every cycle against the DUT outputs.
module tb_key_press_gen;

   logic clk;
   logic rst;
   int   cyc;
   int   n_checks;
   int   n_pass;

   logic [35:0] exp_q[$];
   logic [35:0] rpt_q[$];

   key_press_gen_if if0 ();
   key_press_gen_if if1 ();

   key_press_gen #(
      .DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b0), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
   ) dut0 (
      .clk(clk), .rst(rst), .bus(if0.slave)
   );

   key_press_gen #(
      .DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b1), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
   ) dut1 (
      .clk(clk), .rst(rst), .bus(if1.slave)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic push0(input int at, input logic [3:0] m);
      exp_q.push_back({32'(at), m});
   endtask

   task automatic push1(input int at, input logic [3:0] m);
      rpt_q.push_back({32'(at), m});
   endtask

   // One clock: sample 1 time unit after the edge and score both press vectors
   task automatic tick();
      logic [35:0] head;
      logic [3:0]  e0, e1, o0, o1;
      @(posedge clk);
      #1;
      cyc++;
      e0 = '0;
      e1 = '0;
      if (exp_q.size() > 0) begin
         head = exp_q[0];
         if (head[35:4] == 32'(cyc)) begin
            e0 = head[3:0];
            void'(exp_q.pop_front());
         end
      end
      if (rpt_q.size() > 0) begin
         head = rpt_q[0];
         if (head[35:4] == 32'(cyc)) begin
            e1 = head[3:0];
            void'(rpt_q.pop_front());
         end
      end
      o0 = {if0.key4_press, if0.key3_press, if0.key2_press, if0.key1_press};
      o1 = {if1.key4_press, if1.key3_press, if1.key2_press, if1.key1_press};
      check("press0", 32'(o0), 32'(e0));
      check("any0", 32'(if0.any_press), 32'(|e0));
      check("press1", 32'(o1), 32'(e1));
      check("any1", 32'(if1.any_press), 32'(|e1));
   endtask

   task automatic run_to(input int target);
      while (cyc < target) tick();
   endtask

   initial begin
      int c;
      int d;
      cyc      = 0;
      n_checks = 0;
      n_pass   = 0;
      rst      = 1'b0;
      if0.key_n = 4'hF;
      if1.key_n = 4'hF;

      // reset state
      repeat (3) tick();
      check("rst_level0", 32'(if0.key_level), 32'h0);
      check("rst_level1", 32'(if1.key_level), 32'h0);
      check("rst_state0", 32'(if0.key_state), 32'h0);
      rst = 1'b1;
      repeat (3) tick();

      // clean press of key 1, held 50 cycles
      c = cyc;
      if0.key_n[0] = 1'b0;
      push0(c + 7, 4'b0001);
      run_to(c + 10);
      check("clean_level_held", 32'(if0.key_level), 32'h1);
      check("clean_state_held", 32'(if0.key_state), 32'h02);
      run_to(c + 50);
      if0.key_n[0] = 1'b1;
      run_to(c + 56);
      check("clean_level_before_release", 32'(if0.key_level), 32'h1);
      tick();
      check("clean_level_released", 32'(if0.key_level), 32'h0);
      check("clean_state_idle", 32'(if0.key_state), 32'h00);
      run_to(c + 60);

      // bouncing key 2: two short lows must be rejected
      c = cyc;
      if0.key_n[1] = 1'b0;
      run_to(c + 3);
      if0.key_n[1] = 1'b1;
      run_to(c + 4);
      if0.key_n[1] = 1'b0;
      run_to(c + 7);
      if0.key_n[1] = 1'b1;
      run_to(c + 12);
      check("bounce_level", 32'(if0.key_level), 32'h0);
      c = cyc;
      if0.key_n[1] = 1'b0;
      push0(c + 7, 4'b0010);
      run_to(c + 10);
      check("bounce_then_held", 32'(if0.key_level), 32'h2);
      if0.key_n[1] = 1'b1;
      run_to(c + 20);
      check("bounce_released", 32'(if0.key_level), 32'h0);

      // keys 1 and 4 pressed on the same edge
      c = cyc;
      if0.key_n = 4'b0110;
      push0(c + 7, 4'b1001);
      run_to(c + 9);
      check("simul_level", 32'(if0.key_level), 32'h9);
      if0.key_n = 4'hF;
      run_to(c + 20);
      check("simul_released", 32'(if0.key_level), 32'h0);

      // release bounce while held
      c = cyc;
      if0.key_n[0] = 1'b0;
      push0(c + 7, 4'b0001);
      run_to(c + 10);
      if0.key_n[0] = 1'b1;
      run_to(c + 12);
      if0.key_n[0] = 1'b0;
      run_to(c + 14);
      check("relbounce_level_a", 32'(if0.key_level), 32'h1);
      run_to(c + 20);
      check("relbounce_level_b", 32'(if0.key_level), 32'h1);
      check("relbounce_state", 32'(if0.key_state), 32'h02);
      if0.key_n[0] = 1'b1;
      run_to(c + 26);
      check("relbounce_before_release", 32'(if0.key_level), 32'h1);
      tick();
      check("relbounce_released", 32'(if0.key_level), 32'h0);
      run_to(c + 30);

      // auto-repeat on key 3, held 40 cycles
      c = cyc;
      if1.key_n[2] = 1'b0;
      push1(c + 7,  4'b0100);
      push1(c + 17, 4'b0100);
      push1(c + 22, 4'b0100);
      push1(c + 27, 4'b0100);
      push1(c + 32, 4'b0100);
      push1(c + 37, 4'b0100);
      push1(c + 42, 4'b0100);
      run_to(c + 40);
      check("rpt_level_held", 32'(if1.key_level), 32'h4);
      if1.key_n[2] = 1'b1;
      run_to(c + 55);
      check("rpt_level_released", 32'(if1.key_level), 32'h0);

      // reset while key 1 is debouncing, key kept low through reset
      c = cyc;
      if0.key_n[0] = 1'b0;
      run_to(c + 4);
      check("rstmid_state_pw", 32'(if0.key_state), 32'h01);
      rst = 1'b0;
      run_to(c + 8);
      check("rstmid_level", 32'(if0.key_level), 32'h0);
      check("rstmid_state", 32'(if0.key_state), 32'h00);
      d = cyc;
      rst = 1'b1;
      push0(d + 7, 4'b0001);
      run_to(d + 12);
      check("rstmid_redebounced", 32'(if0.key_level), 32'h1);
      if0.key_n[0] = 1'b1;
      run_to(d + 25);
      check("rstmid_released", 32'(if0.key_level), 32'h0);

      check("exp_q_drained", 32'(exp_q.size()), 32'h0);
      check("rpt_q_drained", 32'(rpt_q.size()), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
